cp0_exc_ctrl: RTL and testbench
===============================

Name: cp0_exc_ctrl

Overview:
- Exception/interrupt commit unit on the consumer side of the CP0 register file.
- Reads status/cause/epc, conditions the raw interrupt lines into the 6-bit IP vector, and arbitrates MEM-stage exceptions, eret and pending interrupts.
- Sequences exception state back into CP0 through its single write port, one field per cycle.
- Stalls the pipeline while sequencing, then emits a one-cycle flush with the redirect PC.

Parameters:
- EXC_VECTOR, 32'h00000020, redirect PC for every exception and interrupt.
- SYNC_STAGES, 2, flop depth of the external interrupt synchronizer (only used with CP0_EXC_INT_SYNC_EN).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- ext_int_i  in  5  raw external interrupt lines
- timer_int_i  in  1  timer interrupt from CP0
- int_o  out  6  IP vector to CP0: {timer_int_i, ext[4:0]}
- status_i, cause_i, epc_i  in  32 each  current CP0 values
- exc_valid_i  in  1  MEM-stage synchronous exception
- exc_code_i  in  5  ExcCode (8 syscall, 10 RI, 12 Ov)
- eret_i  in  1  MEM-stage eret
- exc_pc_i  in  32  PC of the faulting instruction
- in_delay_slot_i  in  1  faulting instruction is in a delay slot
- cp0_we_o  out  1  CP0 write enable
- cp0_waddr_o  out  5  CP0 register number (12 status, 13 cause, 14 epc)
- cp0_data_o  out  32  CP0 write data
- cp0_exc_o  out  1  write originates here; CP0 must accept full cause fields BD[31] and ExcCode[6:2]
- stall_o  out  1  pipeline stall
- flush_o  out  1  pipeline flush, one-cycle pulse
- new_pc_o  out  32  redirect PC, valid with flush_o

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; latched copies 0; synchronizer flops 0.
- int_pending = status_i[0] & ~status_i[1] & |(cause_i[15:8] & status_i[15:8]).
- Trigger evaluation happens only in IDLE. Priority: exc_valid_i > eret_i > int_pending.
- On accept:
  - Latch code: exc_code_i for a synchronous exception, 0 for an interrupt.
  - Latch bd = in_delay_slot_i.
  - Latch epc_val = bd ? exc_pc_i-4 : exc_pc_i, mod 2^32 (wrap, no saturation).
  - Latch status_i, cause_i, epc_i.
- Exception FSM, accept at cycle N:
  - N+1 WR_EPC: we=1, addr 14, data epc_val.
  - N+2 WR_CAUSE: addr 13, data latched cause with [31]=bd and [6:2]=code.
  - N+3 WR_STATUS: addr 12, data latched status with bit1=1.
  - N+4 REDIRECT: flush_o=1, new_pc_o=EXC_VECTOR.
  - N+5 IDLE.
- Eret FSM, accept at cycle N:
  - N+1 WR_STATUS: latched status with bit1=0.
  - N+2 REDIRECT: flush_o=1, new_pc_o=latched epc_i.
- Output rules:
  - cp0_exc_o equals cp0_we_o.
  - stall_o=1 in every non-IDLE state, including REDIRECT.
  - stall_o=0 in the IDLE cycle in which a trigger is accepted, so upstream holds exc inputs for exactly that cycle.
- Triggers arriving while not IDLE are ignored; upstream is stalled and re-presents them.
- Interrupts become blocked after WR_STATUS because EXL=1; no re-entry.
- Interrupt and exception in the same cycle: the exception wins and the interrupt stays pending in cause.
- Reset mid-sequence: immediate return to IDLE; partial CP0 writes already done are not undone.
- int_o is continuous and independent of the FSM.

Optional Feature:
- CP0_EXC_INT_SYNC_EN
  - Defined: ext_int_i passes through a SYNC_STAGES-deep flop synchronizer before int_o[4:0], adding SYNC_STAGES cycles of latency.
  - Undefined: int_o[4:0] = ext_int_i combinationally, for lines already synchronous to clk.
  - timer_int_i is never synchronized.

Decomposition:
- Shared defines:
  - CP0 register numbers (status, cause, epc).
  - ExcCode constants (INT=0, SYS=8, RI=10, OV=12).
  - Status bit indices (IE=0, EXL=1, IM=15:8).
  - FSM state encodings.
  - EXC_VECTOR default.
- One sub-module: cp0_int_sync, a parameterized multi-bit synchronizer, instantiated only under the macro.

Test Plan:
- Syscall: exc_code=8, exc_pc=0x100, not in delay slot, status=0x0000FF01 → writes epc 0x100, then cause[6:2]=8 with BD=0, then status 0x0000FF03; flush_o at N+4 with new_pc=0x20; stall high N+1..N+4.
- Overflow in delay slot: exc_pc=0x204 → epc write 0x200, cause[31]=1, ExcCode=12.
- Timer interrupt: status=0x00008001, cause[15]=1 → accepted with ExcCode 0; after the EXL write, a re-asserted timer is not accepted again.
- Eret: epc_i=0x2000, status=0x00008003 → status write 0x00008001 at N+1, flush with new_pc=0x2000 at N+2.
- Simultaneous syscall and pending interrupt → syscall sequence; exc_pc=0x0 in delay slot gives epc 0xFFFFFFFC (wrap).
- Reset asserted in WR_CAUSE → all outputs 0 asynchronously, FSM IDLE, no flush; with the macro defined, ext_int_i[0] pulse reaches int_o[0] after 2 cycles.

Source files
------------

// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared definitions for the CP0 exception commit unit: register numbers,
// ExcCodes, status bit positions, FSM states and the EPC adjust helper.
package cp0_exc_ctrl_pkg;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_HI = 15;
  localparam int ST_IM_LO = 8;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR_EPC    = 3'd1,
    S_WR_CAUSE  = 3'd2,
    S_WR_STATUS = 3'd3,
    S_REDIRECT  = 3'd4
  } state_e;

  // A delay-slot fault restarts at the branch; wraps modulo 2^32.
  function automatic logic [31:0] epc_adjust(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/cp0_int_sync.sv
// Multi-bit flop synchronizer for asynchronous interrupt lines; STAGES cycles of latency.
module cp0_int_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_d;
  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  always_comb begin
    sync_d[0] = d_i;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt commit unit: arbitrates exceptions, eret and interrupts,
// sequences EPC/Cause/Status writes and redirects. CP0_EXC_INT_SYNC_EN adds an input synchronizer.
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEF,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ext_int_i,
  input  logic        timer_int_i,
  output logic [5:0]  int_o,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        exc_valid_i,
  input  logic [4:0]  exc_code_i,
  input  logic        eret_i,
  input  logic [31:0] exc_pc_i,
  input  logic        in_delay_slot_i,
  output logic        cp0_we_o,
  output logic [4:0]  cp0_waddr_o,
  output logic [31:0] cp0_data_o,
  output logic        cp0_exc_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

`ifdef CP0_EXC_INT_SYNC_EN
  logic [4:0] ext_int_sync;

  cp0_int_sync #(
    .WIDTH  (5),
    .STAGES (SYNC_STAGES)
  ) u_int_sync (
    .clk (clk),
    .rst (rst),
    .d_i (ext_int_i),
    .q_o (ext_int_sync)
  );

  assign int_o = {timer_int_i, ext_int_sync};
`else
  // Synchronizer depth has no meaning when the lines are already clk-synchronous.
  if (SYNC_STAGES < 1) begin : g_sync_depth_unused
  end

  assign int_o = {timer_int_i, ext_int_i};
`endif

  state_e      state_d, state_q;
  logic [31:0] status_d, status_q;
  logic [31:0] cause_d, cause_q;
  logic [31:0] epc_d, epc_q;
  logic [4:0]  code_d, code_q;
  logic        bd_d, bd_q;
  logic        eret_d, eret_q;
  logic        we_d, we_q;
  logic [4:0]  waddr_d, waddr_q;
  logic [31:0] data_d, data_q;
  logic        stall_d, stall_q;
  logic        flush_d, flush_q;
  logic [31:0] new_pc_d, new_pc_q;
  logic        int_pending;

  assign int_pending = status_i[ST_IE] & ~status_i[ST_EXL] &
                       (|(cause_i[ST_IM_HI:ST_IM_LO] & status_i[ST_IM_HI:ST_IM_LO]));

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    code_d   = code_q;
    bd_d     = bd_q;
    eret_d   = eret_q;
    we_d     = 1'b0;
    waddr_d  = 5'd0;
    data_d   = 32'd0;
    flush_d  = 1'b0;
    new_pc_d = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (exc_valid_i || eret_i || int_pending) begin
          status_d = status_i;
          cause_d  = cause_i;
          epc_d    = epc_i;
          bd_d     = in_delay_slot_i;
          we_d     = 1'b1;
          if (!exc_valid_i && eret_i) begin
            eret_d          = 1'b1;
            code_d          = EXC_INT;
            state_d         = S_WR_STATUS;
            waddr_d         = CP0_REG_STATUS;
            data_d          = status_i;
            data_d[ST_EXL]  = 1'b0;
          end else begin
            eret_d  = 1'b0;
            code_d  = exc_valid_i ? exc_code_i : EXC_INT;
            state_d = S_WR_EPC;
            waddr_d = CP0_REG_EPC;
            data_d  = epc_adjust(exc_pc_i, in_delay_slot_i);
          end
        end
      end
      S_WR_EPC: begin
        state_d     = S_WR_CAUSE;
        we_d        = 1'b1;
        waddr_d     = CP0_REG_CAUSE;
        data_d      = cause_q;
        data_d[31]  = bd_q;
        data_d[6:2] = code_q;
      end
      S_WR_CAUSE: begin
        state_d        = S_WR_STATUS;
        we_d           = 1'b1;
        waddr_d        = CP0_REG_STATUS;
        data_d         = status_q;
        data_d[ST_EXL] = 1'b1;
      end
      S_WR_STATUS: begin
        state_d  = S_REDIRECT;
        flush_d  = 1'b1;
        new_pc_d = eret_q ? epc_q : EXC_VECTOR;
      end
      S_REDIRECT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    stall_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      status_q <= '0;
      cause_q  <= '0;
      epc_q    <= '0;
      code_q   <= '0;
      bd_q     <= 1'b0;
      eret_q   <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      data_q   <= '0;
      stall_q  <= 1'b0;
      flush_q  <= 1'b0;
      new_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      code_q   <= code_d;
      bd_q     <= bd_d;
      eret_q   <= eret_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      data_q   <= data_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
    end
  end

  assign cp0_we_o    = we_q;
  assign cp0_exc_o   = we_q;
  assign cp0_waddr_o = waddr_q;
  assign cp0_data_o  = data_q;
  assign stall_o     = stall_q;
  assign flush_o     = flush_q;
  assign new_pc_o    = new_pc_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: exception, eret and interrupt sequences, reset and int_o path.
module tb_cp0_exc_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  ext_int_i;
  logic        timer_int_i;
  logic [5:0]  int_o;
  logic [31:0] status_i, cause_i, epc_i;
  logic        exc_valid_i;
  logic [4:0]  exc_code_i;
  logic        eret_i;
  logic [31:0] exc_pc_i;
  logic        in_delay_slot_i;
  logic        cp0_we_o;
  logic [4:0]  cp0_waddr_o;
  logic [31:0] cp0_data_o;
  logic        cp0_exc_o;
  logic        stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;

  int total  = 0;
  int passed = 0;

  cp0_exc_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .ext_int_i       (ext_int_i),
    .timer_int_i     (timer_int_i),
    .int_o           (int_o),
    .status_i        (status_i),
    .cause_i         (cause_i),
    .epc_i           (epc_i),
    .exc_valid_i     (exc_valid_i),
    .exc_code_i      (exc_code_i),
    .eret_i          (eret_i),
    .exc_pc_i        (exc_pc_i),
    .in_delay_slot_i (in_delay_slot_i),
    .cp0_we_o        (cp0_we_o),
    .cp0_waddr_o     (cp0_waddr_o),
    .cp0_data_o      (cp0_data_o),
    .cp0_exc_o       (cp0_exc_o),
    .stall_o         (stall_o),
    .flush_o         (flush_o),
    .new_pc_o        (new_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] addr, input logic [31:0] data);
    chk({tag, "_we"},    {31'd0, cp0_we_o}, 32'd1);
    chk({tag, "_exc"},   {31'd0, cp0_exc_o}, 32'd1);
    chk({tag, "_addr"},  {27'd0, cp0_waddr_o}, {27'd0, addr});
    chk({tag, "_data"},  cp0_data_o, data);
    chk({tag, "_stall"}, {31'd0, stall_o}, 32'd1);
  endtask

  task automatic chk_redirect(input string tag, input logic [31:0] pc);
    chk({tag, "_flush"}, {31'd0, flush_o}, 32'd1);
    chk({tag, "_newpc"}, new_pc_o, pc);
    chk({tag, "_we0"},   {31'd0, cp0_we_o}, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall_o}, 32'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
    chk({tag, "_flush"}, {31'd0, flush_o}, 32'd0);
    chk({tag, "_we"},    {31'd0, cp0_we_o}, 32'd0);
  endtask

  task automatic clear_trig();
    exc_valid_i     = 1'b0;
    eret_i          = 1'b0;
    exc_code_i      = 5'd0;
    exc_pc_i        = 32'd0;
    in_delay_slot_i = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    ext_int_i   = 5'd0;
    timer_int_i = 1'b0;
    status_i    = 32'd0;
    cause_i     = 32'd0;
    epc_i       = 32'd0;
    clear_trig();

    // Reset state
    #3;
    chk("rst_we",    {31'd0, cp0_we_o}, 32'd0);
    chk("rst_exc",   {31'd0, cp0_exc_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_flush", {31'd0, flush_o}, 32'd0);
    chk("rst_data",  cp0_data_o, 32'd0);
    chk("rst_newpc", new_pc_o, 32'd0);
    chk("rst_addr",  {27'd0, cp0_waddr_o}, 32'd0);
    #9 rst = 1'b1;
    tick();
    chk_idle("post_rst");

    // int_o: timer bit is never synchronized
    timer_int_i = 1'b1;
    #1;
    chk("int_timer", {31'd0, int_o[5]}, 32'd1);
`ifndef CP0_EXC_INT_SYNC_EN
    ext_int_i = 5'b10101;
    #1;
    chk("int_comb", {26'd0, int_o}, 32'h35);
    ext_int_i = 5'b01010;
    #1;
    chk("int_comb2", {26'd0, int_o}, 32'h2A);
    ext_int_i = 5'd0;
`endif
    timer_int_i = 1'b0;
    tick();

    // Syscall, not in delay slot
    status_i    = 32'h0000FF01;
    cause_i     = 32'd0;
    exc_valid_i = 1'b1;
    exc_code_i  = 5'd8;
    exc_pc_i    = 32'h100;
    #1;
    chk("sys_N_stall", {31'd0, stall_o}, 32'd0);
    tick();
    clear_trig();
    status_i = 32'd0;
    chk_wr("sys_epc", 5'd14, 32'h100);
    tick();
    chk_wr("sys_cause", 5'd13, 32'h20);
    tick();
    chk_wr("sys_status", 5'd12, 32'h0000FF03);
    tick();
    chk_redirect("sys_redir", 32'h20);
    tick();
    chk_idle("sys_done");

    // Overflow in delay slot
    status_i        = 32'h0000FF01;
    cause_i         = 32'd0;
    exc_valid_i     = 1'b1;
    exc_code_i      = 5'd12;
    exc_pc_i        = 32'h204;
    in_delay_slot_i = 1'b1;
    tick();
    clear_trig();
    status_i = 32'd0;
    chk_wr("ov_epc", 5'd14, 32'h200);
    tick();
    chk_wr("ov_cause", 5'd13, 32'h80000030);
    tick();
    chk_wr("ov_status", 5'd12, 32'h0000FF03);
    tick();
    chk_redirect("ov_redir", 32'h20);
    tick();
    chk_idle("ov_done");

    // Timer interrupt, then no re-entry once EXL is set
    status_i = 32'h00008001;
    cause_i  = 32'h00008000;
    exc_pc_i = 32'h300;
    #1;
    chk("tmr_N_stall", {31'd0, stall_o}, 32'd0);
    tick();
    exc_pc_i = 32'd0;
    chk_wr("tmr_epc", 5'd14, 32'h300);
    tick();
    chk_wr("tmr_cause", 5'd13, 32'h00008000);
    tick();
    chk_wr("tmr_status", 5'd12, 32'h00008003);
    status_i = 32'h00008003;
    tick();
    chk_redirect("tmr_redir", 32'h20);
    tick();
    chk_idle("tmr_done");
    tick();
    chk_idle("tmr_noreent1");
    tick();
    chk_idle("tmr_noreent2");
    cause_i = 32'd0;

    // Eret
    status_i = 32'h00008003;
    epc_i    = 32'h2000;
    eret_i   = 1'b1;
    #1;
    chk("eret_N_stall", {31'd0, stall_o}, 32'd0);
    tick();
    clear_trig();
    epc_i    = 32'd0;
    status_i = 32'd0;
    chk_wr("eret_status", 5'd12, 32'h00008001);
    tick();
    chk_redirect("eret_redir", 32'h2000);
    tick();
    chk_idle("eret_done");

    // Syscall with pending interrupt; delay slot at PC 0 wraps
    status_i        = 32'h0000FF01;
    cause_i         = 32'h00000400;
    exc_valid_i     = 1'b1;
    exc_code_i      = 5'd8;
    exc_pc_i        = 32'h0;
    in_delay_slot_i = 1'b1;
    tick();
    clear_trig();
    status_i = 32'd0;
    cause_i  = 32'd0;
    chk_wr("both_epc", 5'd14, 32'hFFFFFFFC);
    tick();
    chk_wr("both_cause", 5'd13, 32'h80000420);
    tick();
    chk_wr("both_status", 5'd12, 32'h0000FF03);
    tick();
    chk_redirect("both_redir", 32'h20);
    tick();
    chk_idle("both_done");

    // Asynchronous reset while in WR_CAUSE
    status_i    = 32'h0000FF01;
    exc_valid_i = 1'b1;
    exc_code_i  = 5'd10;
    exc_pc_i    = 32'h40;
    tick();
    clear_trig();
    status_i = 32'd0;
    chk_wr("rmid_epc", 5'd14, 32'h40);
    tick();
    chk_wr("rmid_cause", 5'd13, 32'h28);
    #2 rst = 1'b0;
    #1;
    chk("rmid_we",    {31'd0, cp0_we_o}, 32'd0);
    chk("rmid_exc",   {31'd0, cp0_exc_o}, 32'd0);
    chk("rmid_stall", {31'd0, stall_o}, 32'd0);
    chk("rmid_data",  cp0_data_o, 32'd0);
    chk("rmid_addr",  {27'd0, cp0_waddr_o}, 32'd0);
    #2 rst = 1'b1;
    tick();
    chk_idle("rmid_after1");
    chk("rmid_newpc", new_pc_o, 32'd0);
    tick();
    chk_idle("rmid_after2");

`ifdef CP0_EXC_INT_SYNC_EN
    // Synchronizer latency: a one-cycle pulse appears two cycles later
    ext_int_i = 5'd0;
    tick();
    tick();
    chk("sync_quiet", {31'd0, int_o[0]}, 32'd0);
    ext_int_i = 5'b00001;
    #1;
    chk("sync_lat0", {31'd0, int_o[0]}, 32'd0);
    tick();
    ext_int_i = 5'd0;
    chk("sync_lat1", {31'd0, int_o[0]}, 32'd0);
    tick();
    chk("sync_lat2", {31'd0, int_o[0]}, 32'd1);
    tick();
    chk("sync_clear", {31'd0, int_o[0]}, 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish, required finish before 50000");
    $fatal(1, "timeout");
  end

endmodule
